// File: rtl/gt_cordic_pkg.sv
// Shared constants for the envelope CORDIC: width helpers, the gain and arctangent
// constants, and the FSM state encoding.
package gt_cordic_pkg;

  localparam int ITER_DEF = 16;
  localparam int IW_DEF   = 50;
  localparam int GUARD_W  = 2;

  // 0.607253 * 2^16, the inverse CORDIC gain for 16 micro-rotations
  localparam logic [15:0] GAIN = 16'd39797;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FOLD  = 2'd1,
    ST_ITER  = 2'd2,
    ST_SCALE = 2'd3
  } state_e;

  function automatic int work_w(input int iw);
    return iw + GUARD_W;
  endfunction

  // round(atan(2^-k) * 32768 / pi); steps past the table contribute no angle
  function automatic logic [15:0] atan_lut(input int unsigned k);
    case (k)
      0:       return 16'd8192;
      1:       return 16'd4836;
      2:       return 16'd2555;
      3:       return 16'd1297;
      4:       return 16'd651;
      5:       return 16'd326;
      6:       return 16'd163;
      7:       return 16'd81;
      8:       return 16'd41;
      9:       return 16'd20;
      10:      return 16'd10;
      11:      return 16'd5;
      12:      return 16'd3;
      13:      return 16'd1;
      14:      return 16'd1;
      default: return 16'd0;
    endcase
  endfunction

endpackage

// File: rtl/gt_cordic_iter.sv
// One vectoring micro-rotation, purely combinational: drives y toward zero and
// accumulates the rotated angle in z.
module gt_cordic_iter
  import gt_cordic_pkg::*;
#(
  parameter int WW = 52,
  parameter int KW = 4
) (
  input  logic signed [WW-1:0] x_i,
  input  logic signed [WW-1:0] y_i,
  input  logic signed [WW-1:0] z_i,
  input  logic        [KW-1:0] k_i,
  output logic signed [WW-1:0] x_o,
  output logic signed [WW-1:0] y_o,
  output logic signed [WW-1:0] z_o
);

  logic signed [WW-1:0] xs;
  logic signed [WW-1:0] ys;
  logic signed [WW-1:0] ang;

  always_comb begin
    xs  = x_i >>> k_i;
    ys  = y_i >>> k_i;
    ang = {{(WW-16){1'b0}}, atan_lut(32'(k_i))};
    if (!y_i[WW-1]) begin
      x_o = x_i + ys;
      y_o = y_i - xs;
      z_o = z_i + ang;
    end else begin
      x_o = x_i - ys;
      y_o = y_i + xs;
      z_o = z_i - ang;
    end
  end

endmodule

// File: rtl/gt_envelope_cordic.sv
// Envelope magnitude and phase of an I/Q pair by iterative CORDIC; one pair per
// ITER+3 cycles, result pulse 18 edges after capture, inputs ignored while busy.
module gt_envelope_cordic
  import gt_cordic_pkg::*;
#(
  parameter int ITER = ITER_DEF,
  parameter int IW   = IW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [IW-1:0] i_in,
  input  logic signed [IW-1:0] q_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic        [IW-1:0] mag_out,
  output logic signed [15:0]   phase_out,
  output logic                 out_valid
);

  localparam int WW = work_w(IW);
  localparam int KW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(ITER - 1);
  localparam logic signed [WW-1:0] QTR_TURN = WW'(16384);

  state_e               state_q;
  logic [KW-1:0]        k_q;
  logic signed [IW-1:0] i_q;
  logic signed [IW-1:0] q_q;
  logic                 zero_q;
  logic signed [WW-1:0] x_q;
  logic signed [WW-1:0] y_q;
  logic signed [WW-1:0] z_q;
  logic [IW-1:0]        mag_q;
  logic signed [15:0]   phase_q;
  logic                 out_valid_q;

  logic signed [WW-1:0] i_ext;
  logic signed [WW-1:0] q_ext;
  logic signed [WW-1:0] x_d;
  logic signed [WW-1:0] y_d;
  logic signed [WW-1:0] z_d;
  logic signed [WW-1:0] x_r;
  logic signed [WW-1:0] y_r;
  logic signed [WW-1:0] z_r;
  logic [WW+15:0]       prod;
  logic [IW-1:0]        mag_d;

  assign i_ext = {{GUARD_W{i_q[IW-1]}}, i_q};
  assign q_ext = {{GUARD_W{q_q[IW-1]}}, q_q};

  // Pre-rotate left-half-plane vectors by +/-90 degrees so CORDIC only has to converge
  // over +/-90; the guard bits absorb negating -2^(IW-1).
  always_comb begin
    x_d = i_ext;
    y_d = q_ext;
    z_d = '0;
    if (i_q[IW-1]) begin
      if (!q_q[IW-1]) begin
        x_d = q_ext;
        y_d = -i_ext;
        z_d = QTR_TURN;
      end else begin
        x_d = -q_ext;
        y_d = i_ext;
        z_d = -QTR_TURN;
      end
    end
  end

  gt_cordic_iter #(
    .WW (WW),
    .KW (KW)
  ) u_iter (
    .x_i (x_q),
    .y_i (y_q),
    .z_i (z_q),
    .k_i (k_q),
    .x_o (x_r),
    .y_o (y_r),
    .z_o (z_r)
  );

  // x is non-negative after folding, so an unsigned product is exact
  assign prod  = {16'd0, x_q} * {{WW{1'b0}}, GAIN};
  assign mag_d = IW'(prod >> 16);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      i_q         <= '0;
      q_q         <= '0;
      zero_q      <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      mag_q       <= '0;
      phase_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            i_q     <= i_in;
            q_q     <= q_in;
            zero_q  <= (i_in == '0) && (q_in == '0);
            state_q <= ST_FOLD;
          end
        end
        ST_FOLD: begin
          x_q     <= x_d;
          y_q     <= y_d;
          z_q     <= z_d;
          k_q     <= '0;
          state_q <= ST_ITER;
        end
        ST_ITER: begin
          x_q <= x_r;
          y_q <= y_r;
          z_q <= z_r;
          if (k_q == K_LAST) begin
            state_q <= ST_SCALE;
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        ST_SCALE: begin
          mag_q <= mag_d;
          // a zero vector still walks the rotations and accumulates angle; report 0
          phase_q     <= zero_q ? 16'sd0 : z_q[15:0];
          out_valid_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign mag_out   = mag_q;
  assign phase_out = phase_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_gt_envelope_cordic.sv
// Randomised bench for gt_envelope_cordic: a real-arithmetic sqrt/atan2 model with a
// timing scoreboard predicting captures, result pulses and in_ready.
module tb_gt_envelope_cordic;

  localparam int IW = 50;
  localparam real PI = 3.141592653589793;

  logic                 clk;
  logic                 rst;
  logic signed [IW-1:0] i_in;
  logic signed [IW-1:0] q_in;
  logic                 in_valid;
  logic                 in_ready;
  logic        [IW-1:0] mag_out;
  logic signed [15:0]   phase_out;
  logic                 out_valid;

  gt_envelope_cordic #(
    .ITER (16),
    .IW   (IW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_in      (i_in),
    .q_in      (q_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mag_out   (mag_out),
    .phase_out (phase_out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint i;
    longint q;
    longint due;
    bit     tight;
  } exp_t;

  exp_t   sb[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  longint cyc = 0;
  longint free_at = 0;
  bit     tight = 1'b1;
  bit     exp_ready;
  bit     exp_ov;
  exp_t   cur;

  task automatic chk(input string tag, input longint obs, input longint exp,
                     input longint tol, input bit wrap16);
    longint d;
    n_cmp++;
    d = obs - exp;
    if (wrap16) begin
      d = d & 64'hFFFF;
      if (d > 32767) d = d - 65536;
    end
    if (d < 0) d = -d;
    if (d > tol) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (tol %0d) at cycle %0d", tag, obs, exp, tol, cyc);
    end
  endtask

  task automatic check_result(input exp_t e);
    real    ir, qr, mr;
    longint em, ep, mt, pt;
    ir = real'(e.i);
    qr = real'(e.q);
    mr = $sqrt(ir * ir + qr * qr);
    if (e.i == 0 && e.q == 0) begin
      em = 0; ep = 0; mt = 0; pt = 0;
    end else begin
      em = longint'(mr);
      ep = longint'($atan2(qr, ir) * 32768.0 / PI);
      mt = (em >>> 14) + 64;
      pt = e.tight ? 2 : 5;
    end
    chk("mag", longint'(mag_out), em, mt, 1'b0);
    chk("phase", longint'(phase_out), ep, pt, 1'b1);
    chk("no_x", longint'($isunknown({mag_out, phase_out, out_valid})), 0, 0, 1'b0);
  endtask

  // Scoreboard: a pair is taken when the block is free, the result appears 19 cycles
  // later and the block is free again in that same cycle.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      sb.delete();
      free_at = cyc;
    end else begin
      exp_ready = (cyc >= free_at);
      chk("in_ready", longint'(in_ready), longint'(exp_ready), 0, 1'b0);
      exp_ov = (sb.size() > 0) && (sb[0].due == cyc);
      chk("out_valid", longint'(out_valid), longint'(exp_ov), 0, 1'b0);
      if (exp_ov) begin
        cur = sb.pop_front();
        check_result(cur);
      end
      if (in_valid && exp_ready) begin
        sb.push_back('{longint'(i_in), longint'(q_in), cyc + 19, tight});
        free_at = cyc + 19;
      end
    end
  end

  function automatic longint rnd_s();
    int     s;
    longint v;
    s = $urandom_range(49, 20);
    v = {$urandom, $urandom};
    return v >>> (63 - s);
  endfunction

  task automatic send(input longint a, input longint b);
    bit ok;
    ok = 1'b0;
    i_in = IW'(a);
    q_in = IW'(b);
    in_valid = 1'b1;
    for (int n = 0; n < 64 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) chk("send_ready", longint'(in_ready), 1, 0, 1'b0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 100 && sb.size() != 0; n++) @(negedge clk);
    @(negedge clk);
    chk("drain", longint'(sb.size()), 0, 0, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    longint p2_40, p2_49;
    p2_40 = 64'sd1 <<< 40;
    p2_49 = 64'sd1 <<< 49;
    rst = 1'b1;
    in_valid = 1'b0;
    i_in = '0;
    q_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", longint'(out_valid), 0, 0, 1'b0);
    chk("rst_mag", longint'(mag_out), 0, 0, 1'b0);
    chk("rst_phase", longint'(phase_out), 0, 0, 1'b0);
    chk("rst_in_ready", longint'(in_ready), 1, 0, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed corners
    send(p2_40, 0);
    send(0, p2_40);
    send(-p2_40, -p2_40);
    send(0, 0);
    send(-p2_49, 0);
    send(0, -p2_49);
    send(-p2_49, -p2_49);
    send(p2_49 - 1, p2_49 - 1);
    send(-p2_49, p2_49 - 1);
    wait_drain();

    // Random, sparse valid
    tight = 1'b0;
    for (int n = 0; n < 600; n++) begin
      in_valid = ($urandom_range(3, 0) == 0);
      i_in = IW'(rnd_s());
      q_in = IW'(rnd_s());
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_drain();

    // Valid held high with a fresh pair every cycle
    for (int n = 0; n < 19 * 15; n++) begin
      in_valid = 1'b1;
      i_in = IW'(rnd_s());
      q_in = IW'(rnd_s());
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_drain();

    // Reset in the middle of the rotations (k = 8)
    send(rnd_s(), rnd_s());
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_out_valid", longint'(out_valid), 0, 0, 1'b0);
    chk("abort_mag", longint'(mag_out), 0, 0, 1'b0);
    chk("abort_phase", longint'(phase_out), 0, 0, 1'b0);
    chk("abort_in_ready", longint'(in_ready), 1, 0, 1'b0);
    send(-p2_40, p2_40);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gt_envelope_cordic.md
GT_ENVELOPE_CORDIC -- requirements
Module: gt_envelope_cordic

Interface
REQ-001 Parameter ITER, default 16: number of CORDIC micro-rotations.
REQ-002 Parameter IW, default 50: input sample width, signed two's complement.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port i_in, input, IW: in-phase sample (delayed g_t, 50-bit sign-extended).
REQ-006 Port q_in, input, IW: quadrature sample (Hilbert output, time-aligned with i_in).
REQ-007 Port in_valid, input, 1: i_in/q_in pair is valid this cycle.
REQ-008 Port in_ready, output, 1: block is idle and accepts a pair this cycle.
REQ-009 Port mag_out, output, IW: envelope magnitude, unsigned, gain-compensated.
REQ-010 Port phase_out, output, 16: phase, signed; +32767 ≈ +π, -32768 = -π.
REQ-011 Port out_valid, output, 1: one-cycle pulse; mag_out/phase_out are valid.

Function
REQ-012 FSM states are IDLE, FOLD, ITER, SCALE; in_ready SHALL equal (state == IDLE).
REQ-013 IDLE: a pair SHALL be captured on an edge where in_valid=1 and in_ready=1 (edge E0), and the FSM SHALL move to FOLD.
REQ-014 in_valid while not IDLE SHALL be ignored; it is neither queued nor able to corrupt the sample in progress.
REQ-015 FOLD (edge E1), applied to the sign-extended 52-bit working registers x, y, z:
- I≥0: x=I, y=Q, z=0.
- I<0, Q≥0: x=Q, y=-I, z=+16384.
- I<0, Q<0: x=-Q, y=I, z=-16384.
The FSM then moves to ITER with counter k=0.
REQ-016 ITER, one micro-rotation per edge (E2..E17), k=0..ITER-1:
- If y≥0: x+=y>>>k, y-=x>>>k, z+=ATAN[k].
- Otherwise: the signs are reversed.
- Shifts are arithmetic.
- Both updates use pre-edge x and y.
REQ-017 After k=ITER-1 the FSM SHALL move to SCALE; k SHALL never exceed ITER-1.
REQ-018 SCALE (edge E18):
- mag_out = (x × 39797) >> 16, truncated to IW bits and unsigned.
- phase_out = z[15:0], wrapping modulo 2^16.
- out_valid = 1.
- The FSM returns to IDLE.
REQ-019 Latency: out_valid SHALL be high in exactly the cycle following E18, i.e. 18 edges after the capture edge E0; out_valid SHALL be 0 otherwise.
REQ-020 Throughput: in_ready SHALL reassert in the same cycle out_valid is high, giving one pair per 19 cycles maximum.
REQ-021 mag_out/phase_out SHALL hold their last values until the next SCALE.
REQ-022 Input I=Q=0: mag_out=0 and phase_out=0.
REQ-023 Input -2^49 on either input: no overflow in the 52-bit working width; the result is valid.
REQ-024 I<0, Q=0: phase_out is within ±2 LSB of ±32768, with wrap permitted.

Reset
REQ-025 While rst=1:
- state=IDLE, k=0, x=y=z=0.
- mag_out=0, phase_out=0, out_valid=0.
- in_ready=1 once rst deasserts.
REQ-026 Reset asserted mid-operation SHALL abort the computation; no out_valid pulse SHALL result from the aborted pair.

Structure
REQ-027 Package gt_cordic_pkg SHALL hold:
- ITER default and working width (IW+2).
- Gain constant 39797 (0.607253·2^16).
- The 16-entry ATAN table, round(atan(2^-k)·32768/π): 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0.
- The FSM state encoding.
REQ-028 One combinational sub-module gt_cordic_iter SHALL implement a single micro-rotation (x, y, z, k in; x, y, z out); the FSM, counter and scaling stay in the top module.

Verification
REQ-029 Input I=2^40, Q=0 → mag_out=2^40±2^27, phase_out=0±2, out_valid 18 edges after capture.
REQ-030 Input I=0, Q=2^40 → mag_out=2^40±2^27, phase_out=16384±2; then I=-2^40, Q=-2^40 → mag_out≈1.41421·2^40±2^27, phase_out=-24576±2.
REQ-031 Input I=Q=0 → mag_out=0, phase_out=0; input I=-2^49, Q=0 → mag_out=2^49±2^36, phase_out=±32768±2, no X.
REQ-032 in_valid held high continuously with a changing pair every cycle → exactly one out_valid per 19 cycles, each result matching the pair present at its capture edge.
REQ-033 rst pulsed during ITER (k=8) → out_valid never pulses for that pair, all outputs 0, in_ready=1 after release, and the next pair completes normally.
